fetch_unit: RTL and testbench

- Parametrised instruction-fetch stage that replaces the combinational instruction ROM and bare PC pair.
- Holds a writable instruction memory with synchronous read and a fetch PC with sequential and redirect updates.
- Adds a small output FIFO with a valid/ready handshake toward decode.
- Sits between the branch/ALU redirect source and the decode stage.

---
 rtl/fetch_unit.sv | 120 ++++++++++++
 tb/tb_fetch_unit.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: writable instruction memory with synchronous read,
// a fetch PC with sequential/redirect updates, and a small in-order output FIFO.
module fetch_unit #(
  parameter int unsigned     ADDR_WIDTH = 6,
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     FIFO_DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [XLEN-1:0]       redirect_pc,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [31:0]           prog_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instr,
  output logic [XLEN-1:0]       out_pc,
  output logic                  out_fault,
  output logic [XLEN-1:0]       fetch_pc
);

  localparam int unsigned MEM_DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  logic [31:0]     mem_q   [MEM_DEPTH];
  logic [31:0]     instr_q [FIFO_DEPTH];
  logic [XLEN-1:0] pc_q    [FIFO_DEPTH];
  logic            fault_q [FIFO_DEPTH];

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop_s, issue_s, fault_s, valid_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign valid_s = (count_q != '0);
  assign fault_s = |fetch_pc_q[XLEN-1:ADDR_WIDTH+2];

  // Reset beats redirect, redirect beats issue; a redirect flushes the FIFO.
  always_comb begin
    pop_s      = valid_s && out_ready;
    issue_s    = fetch_en && !redirect_valid && !reset &&
                 ((count_q < CNT_W'(FIFO_DEPTH)) || pop_s);
    fetch_pc_d = fetch_pc_q;
    wr_d       = wr_q;
    rd_d       = rd_q;
    count_d    = count_q;
    if (reset) begin
      fetch_pc_d = RESET_PC;
      wr_d       = '0;
      rd_d       = '0;
      count_d    = '0;
    end else if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ALIGN_MASK;
      wr_d       = '0;
      rd_d       = '0;
      count_d    = '0;
    end else begin
      if (issue_s) begin
        wr_d       = ptr_inc(wr_q);
        fetch_pc_d = fetch_pc_q + XLEN'(4);
      end else begin
        wr_d = wr_q;
      end
      if (pop_s) begin
        rd_d = ptr_inc(rd_q);
      end else begin
        rd_d = rd_q;
      end
      count_d = count_q + CNT_W'(issue_s) - CNT_W'(pop_s);
    end
  end

  always_ff @(posedge clock) begin
    fetch_pc_q <= fetch_pc_d;
    wr_q       <= wr_d;
    rd_q       <= rd_d;
    count_q    <= count_d;
  end

  // Memory read lands straight in the FIFO slot; old data wins on a same-word write.
  always_ff @(posedge clock) begin
    if (prog_we) begin
      mem_q[prog_addr] <= prog_data;
    end
    if (issue_s) begin
      instr_q[wr_q] <= fault_s ? NOP_INSTR : mem_q[fetch_pc_q[ADDR_WIDTH+1:2]];
      pc_q[wr_q]    <= fetch_pc_q;
      fault_q[wr_q] <= fault_s;
    end
  end

  always_comb begin
    out_valid = valid_s;
    fetch_pc  = fetch_pc_q;
    if (valid_s) begin
      out_instr = instr_q[rd_q];
      out_pc    = pc_q[rd_q];
      out_fault = fault_q[rd_q];
    end else begin
      out_instr = 32'h0000_0000;
      out_pc    = '0;
      out_fault = 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a vector table for streaming, stall, redirect,
// fault and reset behaviour, plus hand sequences for program-load ordering.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset, fetch_en, redirect_valid, prog_we, out_ready;
  logic [31:0] redirect_pc, prog_data;
  logic [5:0]  prog_addr;
  logic        out_valid, out_fault;
  logic [31:0] out_instr, out_pc, fetch_pc;

  int tests = 0;
  int fails = 0;

  fetch_unit dut (
    .clock(clock), .reset(reset), .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_fault(out_fault), .fetch_pc(fetch_pc)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst, fe, rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] epc, einstr;
    logic        ef;
    logic [31:0] efp;
  } vec_t;

  vec_t        vecs [31];
  logic [31:0] memw [8];

  function automatic vec_t mk(input logic rst, input logic fe, input logic rv,
                              input logic [31:0] rpc, input logic rdy,
                              input logic ev, input logic [31:0] epc,
                              input logic [31:0] einstr, input logic ef,
                              input logic [31:0] efp);
    vec_t v;
    v.rst = rst; v.fe = fe; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
    v.ev = ev; v.epc = epc; v.einstr = einstr; v.ef = ef; v.efp = efp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (out_valid !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check(name, {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    memw[0] = 32'h0060_0093; memw[1] = 32'h0010_0193;
    memw[2] = 32'h0010_0113; memw[3] = 32'h4211_7133;
    for (int i = 4; i < 8; i++) memw[i] = 32'hA5A5_0000 + 32'(i);

    vecs[0]  = mk(1'b0,1'b1,1'b0,32'h0,1'b1, 1'b0,32'h0,32'h0,1'b0,32'h0);
    vecs[1]  = mk(1'b0,1'b1,1'b0,32'h0,1'b1, 1'b1,32'h0,memw[0],1'b0,32'h4);
    vecs[2]  = mk(1'b0,1'b1,1'b0,32'h0,1'b1, 1'b1,32'h4,memw[1],1'b0,32'h8);
    vecs[3]  = mk(1'b0,1'b1,1'b0,32'h0,1'b1, 1'b1,32'h8,memw[2],1'b0,32'hC);
    vecs[4]  = mk(1'b0,1'b0,1'b0,32'h0,1'b1, 1'b1,32'hC,memw[3],1'b0,32'h10);
    vecs[5]  = mk(1'b0,1'b1,1'b1,32'h0,1'b0, 1'b0,32'h0,32'h0,1'b0,32'h10);
    vecs[6]  = mk(1'b0,1'b1,1'b0,32'h0,1'b0, 1'b0,32'h0,32'h0,1'b0,32'h0);
    vecs[7]  = mk(1'b0,1'b1,1'b0,32'h0,1'b0, 1'b1,32'h0,memw[0],1'b0,32'h4);
    vecs[8]  = mk(1'b0,1'b1,1'b0,32'h0,1'b0, 1'b1,32'h0,memw[0],1'b0,32'h8);
    vecs[9]  = vecs[8];
    vecs[10] = vecs[8];
    vecs[11] = mk(1'b0,1'b1,1'b0,32'h0,1'b1, 1'b1,32'h0,memw[0],1'b0,32'h8);
    vecs[12] = mk(1'b0,1'b1,1'b0,32'h0,1'b1, 1'b1,32'h4,memw[1],1'b0,32'hC);
    vecs[13] = mk(1'b0,1'b1,1'b0,32'h0,1'b0, 1'b1,32'h8,memw[2],1'b0,32'h10);
    vecs[14] = mk(1'b0,1'b1,1'b1,32'h14,1'b0, 1'b1,32'h8,memw[2],1'b0,32'h10);
    vecs[15] = mk(1'b0,1'b1,1'b0,32'h0,1'b1, 1'b0,32'h0,32'h0,1'b0,32'h14);
    vecs[16] = mk(1'b0,1'b1,1'b1,32'h17,1'b1, 1'b1,32'h14,memw[5],1'b0,32'h18);
    vecs[17] = mk(1'b0,1'b1,1'b0,32'h0,1'b1, 1'b0,32'h0,32'h0,1'b0,32'h14);
    vecs[18] = mk(1'b0,1'b1,1'b1,32'h100,1'b1, 1'b1,32'h14,memw[5],1'b0,32'h18);
    vecs[19] = mk(1'b0,1'b1,1'b0,32'h0,1'b1, 1'b0,32'h0,32'h0,1'b0,32'h100);
    vecs[20] = mk(1'b0,1'b1,1'b0,32'h0,1'b1, 1'b1,32'h100,32'h13,1'b1,32'h104);
    vecs[21] = mk(1'b0,1'b1,1'b1,32'h0,1'b1, 1'b1,32'h104,32'h13,1'b1,32'h108);
    vecs[22] = mk(1'b0,1'b1,1'b0,32'h0,1'b0, 1'b0,32'h0,32'h0,1'b0,32'h0);
    vecs[23] = mk(1'b0,1'b1,1'b0,32'h0,1'b0, 1'b1,32'h0,memw[0],1'b0,32'h4);
    vecs[24] = mk(1'b1,1'b1,1'b1,32'h40,1'b0, 1'b1,32'h0,memw[0],1'b0,32'h8);
    vecs[25] = mk(1'b0,1'b1,1'b0,32'h0,1'b1, 1'b0,32'h0,32'h0,1'b0,32'h0);
    vecs[26] = mk(1'b0,1'b0,1'b0,32'h0,1'b1, 1'b1,32'h0,memw[0],1'b0,32'h4);
    vecs[27] = mk(1'b0,1'b0,1'b1,32'hFFFF_FFFE,1'b1, 1'b0,32'h0,32'h0,1'b0,32'h4);
    vecs[28] = mk(1'b0,1'b1,1'b0,32'h0,1'b1, 1'b0,32'h0,32'h0,1'b0,32'hFFFF_FFFC);
    vecs[29] = mk(1'b0,1'b0,1'b0,32'h0,1'b1, 1'b1,32'hFFFF_FFFC,32'h13,1'b1,32'h0);
    vecs[30] = mk(1'b0,1'b0,1'b0,32'h0,1'b0, 1'b0,32'h0,32'h0,1'b0,32'h0);

    reset = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    prog_we = 1'b0; prog_addr = 6'd0; prog_data = 32'h0; out_ready = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      prog_we = 1'b1; prog_addr = 6'(i); prog_data = memw[i];
      step();
    end
    prog_we = 1'b0;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_instr", out_instr, 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_fault", {31'd0, out_fault}, 32'd0);
    check("rst_fetch_pc", fetch_pc, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 31; i++) begin
      check($sformatf("v%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].ev});
      check($sformatf("v%0d_pc", i), out_pc, vecs[i].epc);
      check($sformatf("v%0d_instr", i), out_instr, vecs[i].einstr);
      check($sformatf("v%0d_fault", i), {31'd0, out_fault}, {31'd0, vecs[i].ef});
      check($sformatf("v%0d_fetch_pc", i), fetch_pc, vecs[i].efp);
      reset = vecs[i].rst; fetch_en = vecs[i].fe; redirect_valid = vecs[i].rv;
      redirect_pc = vecs[i].rpc; out_ready = vecs[i].rdy;
      step();
    end
    reset = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0; out_ready = 1'b0;

    // same-cycle write and fetch of word 1 returns the old word
    redirect_valid = 1'b1; redirect_pc = 32'h4;
    step();
    redirect_valid = 1'b0;
    check("rw_redir_pc", fetch_pc, 32'h4);
    fetch_en = 1'b1; prog_we = 1'b1; prog_addr = 6'd1; prog_data = 32'h4030_80B3;
    step();
    fetch_en = 1'b0; prog_we = 1'b0;
    wait_valid("rw_old_wait", 8);
    check("rw_old_pc", out_pc, 32'h4);
    check("rw_old_instr", out_instr, memw[1]);
    check("rw_hold_pc", fetch_pc, 32'h8);

    // re-fetch after redirect sees the new word
    redirect_valid = 1'b1; redirect_pc = 32'h4; out_ready = 1'b1; fetch_en = 1'b1;
    step();
    redirect_valid = 1'b0;
    check("rw_flush_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;
    step();
    fetch_en = 1'b0;
    wait_valid("rw_new_wait", 8);
    check("rw_new_pc", out_pc, 32'h4);
    check("rw_new_instr", out_instr, 32'h4030_80B3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
